// File: rtl/ser_pkg.sv
// Shared constants and helpers for the UART TX parallel-to-serial path.
// Optional parity generation is enabled with the SER_PARITY_EN macro.
package ser_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int LSB_FIRST       = 0;
  localparam int MSB_FIRST_ORDER = 1;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ser_parity_calc.sv
// Combinational parity of a word; type 0 = even, 1 = odd.
// Only instantiated when SER_PARITY_EN is defined.
module ser_parity_calc
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  type_i,
  output logic                  par_o
);

  assign par_o = (^word_i) ^ (type_i == PAR_ODD);

endmodule

// File: rtl/par_serializer.sv
// Double-buffered parallel-to-serial converter for the UART TX path.
// Define SER_PARITY_EN to add the par_type/par_bit parity ports.
module par_serializer
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  ser_active
`ifdef SER_PARITY_EN
  ,
  input  logic                  par_type,
  output logic                  par_bit
`endif
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  data_q, data_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         sel;
  logic                  first_bit;
  logic                  start;

  assign start = ser_en && (cnt_q == '0);

  assign first_bit = (MSB_FIRST == MSB_FIRST_ORDER)
                   ? hold_q[DATA_WIDTH-1]
                   : hold_q[0];

  assign sel = (MSB_FIRST == MSB_FIRST_ORDER)
             ? LAST - cnt_q
             : cnt_q;

  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    cnt_d   = '0;
    data_d  = 1'b0;
    done_d  = 1'b0;
    if (data_valid && !busy)
      hold_d = data_in;
    if (ser_en) begin
      if (cnt_q == '0) begin
        // frame takes the pre-load word; a same-edge load waits
        frame_d = hold_q;
        data_d  = first_bit;
        cnt_d   = ONE;
      end else begin
        data_d = frame_q[sel];
        if (cnt_q == LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign ser_data   = data_q;
  assign ser_done   = done_q;
  assign ser_active = (cnt_q != '0);

`ifdef SER_PARITY_EN
  logic par_calc;
  logic par_q;

  ser_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_par (
    .word_i(hold_q),
    .type_i(par_type),
    .par_o (par_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_q <= 1'b0;
    else if (start)
      par_q <= par_calc;
  end

  assign par_bit = par_q;
`else
  logic unused_start;
  assign unused_start = start;
`endif

endmodule

// File: tb/tb_par_serializer.sv
// Directed bench for par_serializer: 8-bit LSB-first and 12-bit MSB-first.
// Parity checks are compiled in when SER_PARITY_EN is defined.
module tb_par_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       dv8 = 0, busy8 = 0, en8 = 0;
  logic [7:0] din8 = '0;
  logic       sd8, done8, act8;

  logic        dv12 = 0, busy12 = 0, en12 = 0;
  logic [11:0] din12 = '0;
  logic        sd12, done12, act12;

`ifdef SER_PARITY_EN
  logic ptype8 = 0, pbit8;
  logic ptype12 = 0, pbit12;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  par_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_valid(dv8),
    .busy      (busy8),
    .data_in   (din8),
    .ser_en    (en8),
    .ser_data  (sd8),
    .ser_done  (done8),
    .ser_active(act8)
`ifdef SER_PARITY_EN
    ,
    .par_type  (ptype8),
    .par_bit   (pbit8)
`endif
  );

  par_serializer #(.DATA_WIDTH(12), .MSB_FIRST(1)) dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_valid(dv12),
    .busy      (busy12),
    .data_in   (din12),
    .ser_en    (en12),
    .ser_data  (sd12),
    .ser_done  (done12),
    .ser_active(act12)
`ifdef SER_PARITY_EN
    ,
    .par_type  (ptype12),
    .par_bit   (pbit12)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load8(input logic [7:0] w);
    dv8  = 1'b1;
    din8 = w;
    @(negedge clk);
    dv8  = 1'b0;
  endtask

  // ser_en is left high on return so frames can run back-to-back
  task automatic frame8(input string tag, input logic [7:0] w,
                        input int ld_at, input logic [7:0] ld_w);
    en8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, ".bit"}, 32'(sd8), 32'(w[i]));
      chk({tag, ".done"}, 32'(done8), 32'(i == 7));
      chk({tag, ".act"}, 32'(act8), 32'(i != 7));
      dv8 = (i == ld_at);
      if (i == ld_at) din8 = ld_w;
    end
    dv8 = 1'b0;
  endtask

  initial begin
    logic [11:0] w12;

    #2;
    chk("rst.sd8", 32'(sd8), 0);
    chk("rst.done8", 32'(done8), 0);
    chk("rst.act8", 32'(act8), 0);
    chk("rst.sd12", 32'(sd12), 0);
`ifdef SER_PARITY_EN
    chk("rst.par8", 32'(pbit8), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8'hA5 LSB first
    load8(8'hA5);
    frame8("a5", 8'hA5, -1, 8'h00);
    en8 = 1'b0;
    @(negedge clk);
    chk("idle.sd8", 32'(sd8), 0);

    // 12'hC35 MSB first
    w12 = 12'hC35;
    dv12 = 1'b1;
    din12 = w12;
    @(negedge clk);
    dv12 = 1'b0;
    en12 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("c35.bit", 32'(sd12), 32'(w12[11-i]));
      chk("c35.done", 32'(done12), 32'(i == 11));
    end
    en12 = 1'b0;

    // mid-frame load, back-to-back, busy blocks load
    load8(8'h0F);
    frame8("0f", 8'h0F, 2, 8'hF0);
    frame8("f0", 8'hF0, -1, 8'h00);
    busy8 = 1'b1;
    frame8("f0b", 8'hF0, 0, 8'hAA);
    frame8("f0r", 8'hF0, -1, 8'h00);
    busy8 = 1'b0;
    en8 = 1'b0;
    @(negedge clk);

    // abandon after 4 bits, then restart
    load8(8'h3C);
    en8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("3c.part", 32'(sd8), 32'(i >= 2));
      chk("3c.pdone", 32'(done8), 0);
    end
    en8 = 1'b0;
    @(negedge clk);
    chk("3c.drop.sd", 32'(sd8), 0);
    chk("3c.drop.act", 32'(act8), 0);
    chk("3c.drop.done", 32'(done8), 0);
    frame8("3c", 8'h3C, -1, 8'h00);
    en8 = 1'b0;
    @(negedge clk);

    // asynchronous reset mid-frame
    load8(8'hFF);
    en8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstm.act", 32'(act8), 1);
    chk("rstm.sd", 32'(sd8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm.sd0", 32'(sd8), 0);
    chk("rstm.act0", 32'(act8), 0);
    chk("rstm.done0", 32'(done8), 0);
    en8 = 1'b0;
    @(negedge clk);
    chk("rstm.hold", 32'(sd8), 0);
    rst_n = 1'b1;
    @(negedge clk);
    frame8("zero", 8'h00, -1, 8'h00);
    en8 = 1'b0;
    @(negedge clk);
    load8(8'h81);
    frame8("81", 8'h81, -1, 8'h00);
    en8 = 1'b0;
    @(negedge clk);

    // load on the frame-start edge: old word goes out first
    dv8 = 1'b1;
    din8 = 8'h5A;
    frame8("same", 8'h81, -1, 8'h00);
    frame8("5a", 8'h5A, -1, 8'h00);
    en8 = 1'b0;
    @(negedge clk);

`ifdef SER_PARITY_EN
    load8(8'h07);
    ptype8 = 1'b0;
    en8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("par.even", 32'(pbit8), 1);
      ptype8 = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("par.odd", 32'(pbit8), 0);
      ptype8 = 1'b0;
    end
    en8 = 1'b0;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
